// File: rtl/midi_pkg.sv
// Shared MIDI decoder types, status constants and octave -1 period table.
// Imported by note_period_lut and midi_note_decoder.
package midi_pkg;

  typedef enum logic [2:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2,
    SKIP,
    SYSEX
  } parse_state_t;

  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // Clock cycles per period for notes 0..11 (octave -1), 50 MHz clock.
  localparam logic [23:0] NOTE_PERIOD [0:11] = '{
    24'd6115610, 24'd5772339, 24'd5448404, 24'd5142604,
    24'd4853945, 24'd4581432, 24'd4324399, 24'd4081666,
    24'd3852585, 24'd3636364, 24'd3432275, 24'd3239589
  };

endpackage

// File: rtl/note_period_lut.sv
// Registered note -> playback period stage (one cycle latency).
// Ports: clk_in, rst_in, note_in[6:0], valid_in -> period_out[23:0], valid_out.
module note_period_lut
  import midi_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [6:0]  note_in,
  input  logic        valid_in,
  output logic [23:0] period_out,
  output logic        valid_out
);

  logic [3:0]  w_idx;
  logic [3:0]  w_oct;
  logic [23:0] w_period;
  logic [23:0] r_period;
  logic        r_valid;

  assign w_idx    = 4'(note_in % 7'd12);
  assign w_oct    = 4'(note_in / 7'd12);
  // Each octave halves the period of the octave -1 entry.
  assign w_period = NOTE_PERIOD[w_idx] >> w_oct;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid  <= 1'b0;
      r_period <= '0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) r_period <= w_period;
    end
  end

  assign period_out = r_period;
  assign valid_out  = r_valid;

endmodule

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser emitting note on/off events with playback period.
// Ports: clk_in, rst_in, byte_in[7:0], byte_valid_in -> valid_out,
// isNoteOn, cycles_between_samples[23:0], note_out[6:0].
// Macro MIDI_RUNNING_STATUS_EN: keep running status after each event.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        valid_out,
  output logic        isNoteOn,
  output logic [23:0] cycles_between_samples,
  output logic [6:0]  note_out
);

  parse_state_t r_state;
  parse_state_t w_next;

  logic       r_on_type;
  logic [6:0] r_note;
  logic       r_evt_valid;
  logic [6:0] r_evt_note;
  logic       r_evt_on;
  logic       r_is_on;
  logic [6:0] r_note_out;

  logic w_rt;
  logic w_status;
  logic w_data;
  logic w_ch_ok;
  logic w_note_stat;
  logic w_emit;
  logic w_evt_on;

  // Real-time bytes are invisible to the parser.
  assign w_rt     = byte_valid_in && (byte_in >= REALTIME_MIN);
  assign w_status = byte_valid_in && byte_in[7] && !w_rt;
  assign w_data   = byte_valid_in && !byte_in[7];
  assign w_ch_ok  = OMNI || (byte_in[3:0] == 4'(CHANNEL));
  assign w_note_stat = w_ch_ok &&
    ((byte_in[7:4] == NOTE_ON) || (byte_in[7:4] == NOTE_OFF));

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= NO_STATUS;
    else        r_state <= w_next;
  end

  // Inside SYSEX, F7 lands in NO_STATUS like any other system status.
  always_comb begin
    w_next = r_state;
    if (w_status) begin
      if (byte_in == SYSEX_START)     w_next = SYSEX;
      else if (byte_in[7:4] == 4'hF)  w_next = NO_STATUS;
      else if (w_note_stat)           w_next = WAIT_D1;
      else                            w_next = SKIP;
    end else if (w_data) begin
      unique case (r_state)
        WAIT_D1: w_next = WAIT_D2;
`ifdef MIDI_RUNNING_STATUS_EN
        WAIT_D2: w_next = WAIT_D1;
`else
        WAIT_D2: w_next = NO_STATUS;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_emit   = w_data && (r_state == WAIT_D2);
    w_evt_on = r_on_type && (byte_in[6:0] != 7'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_on_type   <= 1'b0;
      r_note      <= '0;
      r_evt_valid <= 1'b0;
      r_evt_note  <= '0;
      r_evt_on    <= 1'b0;
      r_is_on     <= 1'b0;
      r_note_out  <= '0;
    end else begin
      if (w_status) r_on_type <= w_note_stat && (byte_in[7:4] == NOTE_ON);
      if (w_data && r_state == WAIT_D1) r_note <= byte_in[6:0];
      r_evt_valid <= w_emit;
      if (w_emit) begin
        r_evt_note <= r_note;
        r_evt_on   <= w_evt_on;
      end
      // Event flags follow the LUT stage so all outputs change together.
      if (r_evt_valid) begin
        r_is_on    <= r_evt_on;
        r_note_out <= r_evt_note;
      end
    end
  end

  note_period_lut u_lut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .note_in    (r_evt_note),
    .valid_in   (r_evt_valid),
    .period_out (cycles_between_samples),
    .valid_out  (valid_out)
  );

  assign isNoteOn = r_is_on;
  assign note_out = r_note_out;

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 Parameter CHANNEL, default 0, is the MIDI channel (0-15) accepted when OMNI=0.
REQ-002 Parameter OMNI, default 0; when 1, note messages on all channels are accepted.
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 byte_in  input  8  received MIDI byte from the UART receiver.
REQ-006 byte_valid_in  input  1  byte_in is valid this cycle; one byte per asserted cycle, back-to-back allowed.
REQ-007 valid_out  output  1  one-cycle pulse marking a decoded note event.
REQ-008 isNoteOn  output  1  1 = note on, 0 = note off; held between events.
REQ-009 cycles_between_samples  output  24  playback period for the event's note; held between events.
REQ-010 note_out  output  7  MIDI note number of the last event; held.

Function
REQ-011 Parser FSM states: NO_STATUS, WAIT_D1, WAIT_D2, SKIP, SYSEX.
REQ-012 Status byte 0x9n or 0x8n with matching channel: latch status, go to WAIT_D1.
REQ-013 Any other channel-voice status (0x80-0xEF not accepted): go to SKIP; data bytes are discarded until the next status byte.
REQ-014 0xF0: go to SYSEX; all data bytes discarded; 0xF7 or any other status byte exits.
REQ-015 0xF1-0xF7 (not inside SYSEX): clear running status, go to NO_STATUS.
REQ-016 Real-time bytes 0xF8-0xFF are ignored in every state with no change to FSM, running status, or latched data.
REQ-017 Data byte (bit 7 = 0) in WAIT_D1: latch as note, go to WAIT_D2. Data byte in NO_STATUS: discarded.
REQ-018 Data byte in WAIT_D2: latch as velocity, emit the event, go to WAIT_D1 (running status).
REQ-019 Event type: 0x9n with velocity != 0 -> isNoteOn=1; 0x9n with velocity 0, or 0x8n with any velocity -> isNoteOn=0.
REQ-020 Latency: if the velocity byte is accepted in cycle N, valid_out pulses in cycle N+2, and isNoteOn, note_out, and cycles_between_samples are valid in the same cycle.
REQ-021 Period: cycles_between_samples = NOTE_PERIOD[note mod 12] >> (note / 12), unsigned, 24 bits, truncating shift.
REQ-022 valid_out is high for exactly one cycle per event; consecutive events can be one cycle apart at minimum.
REQ-023 A new status byte arriving in WAIT_D2 abandons the partial message without emitting, then is processed per REQ-012 to REQ-015.

Reset
REQ-024 While rst_in is high: FSM = NO_STATUS, running status cleared, valid_out=0, isNoteOn=0, note_out=0, cycles_between_samples=0, and the LUT pipeline stage is flushed.
REQ-025 Reset in cycle N+1 of REQ-020 suppresses the pending pulse; after reset, a data byte without a preceding status emits nothing.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN. Defined: REQ-018 returns to WAIT_D1. Undefined: after emitting, the FSM goes to NO_STATUS, so every message needs its own status byte and extra data bytes are discarded.

Structure
REQ-027 Package midi_pkg holds the parser state enum, the status constants (NOTE_ON=4'h9, NOTE_OFF=4'h8, SYSEX_START=8'hF0, SYSEX_END=8'hF7, REALTIME_MIN=8'hF8), and the NOTE_PERIOD[0:11] 24-bit table for octave -1, which the team's tuning script generates for the system clock.
REQ-028 Sub-module note_period_lut performs REQ-021 as one registered stage: 7-bit note plus valid in, 24-bit period plus valid out.

Verification
REQ-029 Bytes 90 45 64 (CHANNEL=0) -> one pulse 2 cycles after the 0x64 byte; isNoteOn=1, note_out=69, period = NOTE_PERIOD[9]>>5.
REQ-030 Running status: 90 3C 40 3C 00 -> two pulses: note 60 on, then note 60 off; with MIDI_RUNNING_STATUS_EN undefined -> only the first pulse.
REQ-031 90 F8 3C FE 40, with real-time bytes interleaved -> one note-on for note 60 with timing relative to the 0x40 byte; no state disturbance.
REQ-032 CHANNEL=0, OMNI=0: 91 3C 40 and B0 07 7F -> no pulses; the same 91 sequence with OMNI=1 -> note-on.
REQ-033 F0 3C 40 F7 then 80 3C 7F -> only one pulse (note off, note 60); SysEx data is not parsed.
REQ-034 rst_in asserted for one cycle right after the 0x40 of 90 3C 40 -> no pulse, all outputs 0; a following 3C 40 without status -> no pulse.
